// File: rtl/femto_pkg.sv
// Shared constants and types for the FemtoRV32 pipeline stage registers.
// Holds the datapath width, the default reset payload and the stage occupancy encoding.
// The state codes are the concatenation {skid valid, main valid}.
package femto_pkg;

    localparam int XLEN = 32;

    // Default payload value of the stage data registers after reset.
    localparam logic [XLEN-1:0] DEFAULT_RESET_VALUE = '0;

    // Occupancy of a skid stage. 2'b10 (skid valid, main empty) is never reached.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b11
    } skid_state_e;

endpackage

// File: rtl/en_reg.sv
// Load-enabled register with asynchronous active-low reset to a fixed value.
// Latency: q follows d one clock after an enabled edge.
// Backpressure: none; it holds whenever en is low.
module en_reg
    import femto_pkg::*;
#(
    parameter int                WIDTH       = XLEN,
    parameter logic [WIDTH-1:0]  RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    // Capture d on enabled edges; reset forces the configured value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= RESET_VALUE;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer and synchronous flush.
// Latency: a payload accepted on an edge is presented on out_data right after that edge.
// Backpressure: in_ready is registered (~skid valid); one extra payload is absorbed after out_ready drops.
module pipe_skid_reg
    import femto_pkg::*;
#(
    parameter int                WIDTH       = XLEN,
    parameter logic [WIDTH-1:0]  RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       level
);

    logic             m_valid_q, m_valid_d;
    logic             s_valid_q, s_valid_d;
    logic             m_en, s_en, m_sel_skid;
    logic [WIDTH-1:0] m_data_q, s_data_q;
    logic [WIDTH-1:0] m_data_d;
    logic             in_fire, out_fire;
    skid_state_e      state;

    // Handshake outputs come straight from the valid registers so no input
    // reaches in_ready or out_valid combinationally.
    assign in_ready  = ~s_valid_q;
    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;
    assign level     = {1'b0, m_valid_q} + {1'b0, s_valid_q};

    assign in_fire  = in_valid & ~s_valid_q;
    assign out_fire = m_valid_q & out_ready;

    assign state = skid_state_e'({s_valid_q, m_valid_q});

    // Next occupancy and data-register load enables; flush overrides everything
    // and leaves the data registers untouched.
    always_comb begin
        m_valid_d  = m_valid_q;
        s_valid_d  = s_valid_q;
        m_en       = 1'b0;
        s_en       = 1'b0;
        m_sel_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    m_en      = 1'b1;
                    m_valid_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (in_fire && out_fire) begin
                    m_en = 1'b1;
                end else if (in_fire) begin
                    s_en      = 1'b1;
                    s_valid_d = 1'b1;
                end else if (out_fire) begin
                    m_valid_d = 1'b0;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the drain path can move data.
                if (out_fire) begin
                    m_en       = 1'b1;
                    m_sel_skid = 1'b1;
                    s_valid_d  = 1'b0;
                end
            end
            default: begin
                m_valid_d = 1'b0;
                s_valid_d = 1'b0;
            end
        endcase
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
            m_en      = 1'b0;
            s_en      = 1'b0;
        end
    end

    assign m_data_d = m_sel_skid ? s_data_q : in_data;

    // Valid bits: reset empties the stage immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
        end
    end

    en_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_main_reg (
        .clk (clk),
        .rst (rst),
        .en  (m_en),
        .d   (m_data_d),
        .q   (m_data_q)
    );

    en_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_skid_reg (
        .clk (clk),
        .rst (rst),
        .en  (s_en),
        .d   (in_data),
        .q   (s_data_q)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table on a 32-bit stage,
// asynchronous reset sequence, and a queue-based random run on 8- and 64-bit stages.
module tb_pipe_skid_reg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // 32-bit stage for directed vectors
    logic        iv32, ir32, ov32, or32, fl32;
    logic [31:0] id32, od32;
    logic [1:0]  lv32;

    // 8-bit and 64-bit stages share handshake controls in the random run
    logic        iv_r, or_r, fl_r;
    logic        ir8, ov8, ir64, ov64;
    logic [7:0]  id8, od8;
    logic [63:0] id64, od64;
    logic [1:0]  lv8, lv64;

    pipe_skid_reg #(.WIDTH(32), .RESET_VALUE(32'h0)) dut32 (
        .clk(clk), .rst(rst_n), .in_valid(iv32), .in_ready(ir32), .in_data(id32),
        .out_valid(ov32), .out_ready(or32), .out_data(od32), .flush(fl32), .level(lv32));

    pipe_skid_reg #(.WIDTH(8), .RESET_VALUE(8'h0)) dut8 (
        .clk(clk), .rst(rst_n), .in_valid(iv_r), .in_ready(ir8), .in_data(id8),
        .out_valid(ov8), .out_ready(or_r), .out_data(od8), .flush(fl_r), .level(lv8));

    pipe_skid_reg #(.WIDTH(64), .RESET_VALUE(64'h0)) dut64 (
        .clk(clk), .rst(rst_n), .in_valid(iv_r), .in_ready(ir64), .in_data(id64),
        .out_valid(ov64), .out_ready(or_r), .out_data(od64), .flush(fl_r), .level(lv64));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic        e_ir;
        logic [1:0]  e_lvl;
        logic [31:0] e_od;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic iv, input logic [31:0] id, input logic ordy,
                                input logic fl, input logic e_ov, input logic e_ir,
                                input logic [1:0] e_lvl, input logic [31:0] e_od);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_lvl = e_lvl; v.e_od = e_od;
        return v;
    endfunction

    // Reference contents of the random-run stages, oldest first
    logic [63:0] sb8[$];
    logic [63:0] sb64[$];

    task automatic check_stage(input string tag, input logic ov, input logic ir,
                               input logic [1:0] lvl, input logic [63:0] od,
                               input int sz, input logic [63:0] head);
        check({tag, " out_valid"}, {63'b0, ov}, {63'b0, sz > 0});
        check({tag, " in_ready"}, {63'b0, ir}, {63'b0, sz < 2});
        check({tag, " level"}, {62'b0, lvl}, 64'(sz));
        if (sz > 0) check({tag, " out_data order"}, od, head);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        iv32 = 0; id32 = 0; or32 = 0; fl32 = 0;
        iv_r = 0; or_r = 0; fl_r = 0; id8 = 0; id64 = 0;

        // Streaming 0x1..0x8 with out_ready high, then drain
        for (int k = 1; k <= 8; k++) vecs.push_back(mk(1, 32'(k), 1, 0, 1, 1, 1, 32'(k)));
        vecs.push_back(mk(0, 32'h0,  1, 0, 0, 1, 0, 32'h8));
        // Backpressure: skid fills, extra payload refused, then drain in order
        vecs.push_back(mk(1, 32'h10, 0, 0, 1, 1, 1, 32'h10));
        vecs.push_back(mk(1, 32'h11, 0, 0, 1, 0, 2, 32'h10));
        vecs.push_back(mk(1, 32'h12, 0, 0, 1, 0, 2, 32'h10));
        vecs.push_back(mk(0, 32'h0,  1, 0, 1, 1, 1, 32'h11));
        vecs.push_back(mk(0, 32'h0,  1, 0, 0, 1, 0, 32'h11));
        // Simultaneous accept and deliver in BUSY
        vecs.push_back(mk(1, 32'h20, 0, 0, 1, 1, 1, 32'h20));
        vecs.push_back(mk(1, 32'h21, 1, 0, 1, 1, 1, 32'h21));
        vecs.push_back(mk(0, 32'h0,  1, 0, 0, 1, 0, 32'h21));
        // Flush from FULL with a payload presented; data registers keep contents
        vecs.push_back(mk(1, 32'h30, 0, 0, 1, 1, 1, 32'h30));
        vecs.push_back(mk(1, 32'h31, 0, 0, 1, 0, 2, 32'h30));
        vecs.push_back(mk(1, 32'h32, 0, 1, 0, 1, 0, 32'h30));
        // Flush in BUSY with both handshakes firing drops the incoming payload
        vecs.push_back(mk(1, 32'h33, 0, 0, 1, 1, 1, 32'h33));
        vecs.push_back(mk(1, 32'h34, 1, 1, 0, 1, 0, 32'h33));
        vecs.push_back(mk(1, 32'h35, 1, 0, 1, 1, 1, 32'h35));
        vecs.push_back(mk(0, 32'h0,  1, 0, 0, 1, 0, 32'h35));
        // Data may change freely while in_valid is low
        vecs.push_back(mk(0, 32'hFF, 0, 0, 0, 1, 0, 32'h35));
        // Fill to FULL with 0xA, 0xB ahead of the reset sequence
        vecs.push_back(mk(1, 32'hA,  0, 0, 1, 1, 1, 32'hA));
        vecs.push_back(mk(1, 32'hB,  0, 0, 1, 0, 2, 32'hA));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", {63'b0, ov32}, 64'd0);
        check("reset in_ready",  {63'b0, ir32}, 64'd1);
        check("reset level",     {62'b0, lv32}, 64'd0);
        check("reset out_data",  {32'b0, od32}, 64'd0);
        rst_n = 1'b1;

        // Directed vector table
        foreach (vecs[i]) begin
            iv32 = vecs[i].iv; id32 = vecs[i].id; or32 = vecs[i].ordy; fl32 = vecs[i].fl;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid", i), {63'b0, ov32}, {63'b0, vecs[i].e_ov});
            check($sformatf("vec%0d in_ready", i),  {63'b0, ir32}, {63'b0, vecs[i].e_ir});
            check($sformatf("vec%0d level", i),     {62'b0, lv32}, {62'b0, vecs[i].e_lvl});
            check($sformatf("vec%0d out_data", i),  {32'b0, od32}, {32'b0, vecs[i].e_od});
        end

        // Asynchronous reset mid-FULL takes effect without a clock edge
        iv32 = 0; or32 = 0;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", {63'b0, ov32}, 64'd0);
        check("async rst in_ready",  {63'b0, ir32}, 64'd1);
        check("async rst level",     {62'b0, lv32}, 64'd0);
        check("async rst out_data",  {32'b0, od32}, 64'd0);
        @(posedge clk);
        #1;
        // First acceptance on the first edge after release
        rst_n = 1'b1;
        iv32 = 1; id32 = 32'h40;
        @(posedge clk);
        #1;
        check("post-reset accept out_data", {32'b0, od32}, 64'h40);
        check("post-reset accept level",    {62'b0, lv32}, 64'd1);
        iv32 = 0; or32 = 1;
        @(posedge clk);
        #1;
        check("post-reset drain level", {62'b0, lv32}, 64'd0);
        or32 = 0;

        // Random run on 8- and 64-bit stages with a reference queue per stage
        sb8.delete();
        sb64.delete();
        for (int c = 0; c < 10000; c++) begin
            logic        acc8, acc64, del8, del64;
            logic [63:0] h8, h64;
            iv_r = ($urandom_range(0, 9) < 7);
            or_r = ($urandom_range(0, 9) < 6);
            fl_r = ($urandom_range(0, 15) == 0);
            id8  = 8'($urandom);
            id64 = {$urandom, $urandom};
            h8  = (sb8.size()  > 0) ? sb8[0]  : 64'h0;
            h64 = (sb64.size() > 0) ? sb64[0] : 64'h0;
            check_stage("w8",  ov8,  ir8,  lv8,  {56'b0, od8}, sb8.size(),  h8);
            check_stage("w64", ov64, ir64, lv64, od64,         sb64.size(), h64);
            acc8  = iv_r && (sb8.size()  < 2);
            acc64 = iv_r && (sb64.size() < 2);
            del8  = or_r && (sb8.size()  > 0);
            del64 = or_r && (sb64.size() > 0);
            if (fl_r) begin
                sb8.delete();
                sb64.delete();
            end else begin
                if (del8)  void'(sb8.pop_front());
                if (del64) void'(sb64.pop_front());
                if (acc8)  sb8.push_back({56'b0, id8});
                if (acc64) sb64.push_back(id64);
            end
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register for the FemtoRV32 datapath, generalising the load-enabled 32-bit register to arbitrary width with a valid/ready handshake, a two-entry skid buffer and synchronous flush. It sits between pipeline stages, for example IF/ID and ID/EX, as we move from single-cycle to pipelined execution. The skid buffer registers `in_ready`, which breaks the combinational ready path back through the stage. It sustains one transfer per cycle.

## Interface
- `WIDTH`, 32: payload width in bits (≥1).
- `RESET_VALUE`, 0: value of both data registers after reset (WIDTH bits).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream payload valid.
- `in_ready` output 1: stage can accept; driven directly from a register.
- `in_data` input WIDTH: upstream payload.
- `out_valid` output 1: `out_data` holds a valid payload.
- `out_ready` input 1: downstream accepts.
- `out_data` output WIDTH: payload; driven directly from the main register.
- `flush` input 1: synchronous discard of all held payloads.
- `level` output 2: occupancy, 0, 1 or 2.

## Operation
- Accept: `in_fire = in_valid & in_ready`.
- Deliver: `out_fire = out_valid & out_ready`.
- Storage:
  - main register `m_data`/`m_valid` drives the output;
  - skid register `s_data`/`s_valid`.
- State is encoded by the valid bits:
  - EMPTY: `m_valid=0`, `s_valid=0`.
  - BUSY: `m_valid=1`, `s_valid=0`.
  - FULL: `m_valid=1`, `s_valid=1`.
- `in_ready = ~s_valid`. `out_valid = m_valid`. `level = m_valid + s_valid`.
- Transitions when `flush=0`:
  - EMPTY, `in_fire`: `m_data <= in_data`, go to BUSY. Otherwise stay.
  - BUSY, `in_fire & out_fire`: `m_data <= in_data`, stay BUSY.
  - BUSY, `in_fire` only: `s_data <= in_data`, go to FULL.
  - BUSY, `out_fire` only: go to EMPTY.
  - BUSY, neither: hold.
  - FULL: `in_fire` is impossible because `in_ready=0`.
  - FULL, `out_fire`: `m_data <= s_data`, go to BUSY. Otherwise hold.
- Flush:
  - `flush=1` has highest priority: the next state is EMPTY regardless of `in_fire`/`out_fire`.
  - A payload presented with `in_fire` in the flush cycle is dropped.
  - A payload with `out_fire` in the flush cycle counts as delivered; downstream sampled it.
  - Data registers are not modified by flush.
- Data registers load only on the transfers listed above; otherwise they hold, and are never cleared except by reset.
- Ordering: payloads leave in acceptance order. No duplication, and no loss except by flush or reset.

## Timing
- Reset, asserted asynchronously:
  - `m_valid=0`, `s_valid=0`;
  - `in_ready=1`, `out_valid=0`, `level=0`;
  - `m_data=s_data=out_data=RESET_VALUE`.
- Release is synchronous to `clk`; the first acceptance is possible on the first rising edge after release.
- Latency: a payload accepted at edge N is on `out_data` with `out_valid=1` immediately after edge N, so it is deliverable in cycle N+1.
- Throughput: with `out_ready` held at 1, one payload per cycle and the block never leaves BUSY.
- Backpressure:
  - `in_ready` falls the cycle after the skid fills.
  - Exactly one extra payload is absorbed after `out_ready` drops.
- `in_ready` and `out_valid` have no combinational dependence on any input.
- Reset mid-operation discards all held payloads immediately.
- Upstream may change `in_data` freely while `in_valid=0`.
- The block does not require upstream to hold a payload once it is not accepted.

## Structure
- Shared package `femto_pkg`: `XLEN=32` and the default `RESET_VALUE` constant.
- Sub-module `en_reg` (params `WIDTH`, `RESET_VALUE`; ports `clk`, `rst`, `en`, `d`, `q`):
  - async active-low reset, load when `en=1`;
  - instantiated twice, for the main and skid data.
- Valid bits and the next-state logic live in `pipe_skid_reg`.

## Test plan
- **Reset:** assert `rst=0` mid-FULL with `m_data=0xA`, `s_data=0xB` → immediately `out_valid=0`, `in_ready=1`, `level=0`, `out_data=0`.
- **Streaming:** drive 0x1..0x8 on consecutive cycles, `out_ready=1` → `out_data` sequence 0x1..0x8, each one cycle later; `level=1` throughout; `in_ready` never 0.
- **Backpressure:**
  - accept 0x10, 0x11 with `out_ready=0` → `level=2`, `in_ready=0`, `out_data=0x10`;
  - raise `out_ready` → 0x10 then 0x11 delivered, `level` goes 2→1→0.
- **Simultaneous fire in BUSY:** `m_data=0x20`, `in_data=0x21`, both handshakes fire → next cycle `out_data=0x21`, `level=1`.
- **Flush:** FULL (0x30, 0x31) plus `flush=1` with `in_valid=1`, `in_data=0x32` → next cycle `level=0`, `out_valid=0`; 0x32 never appears at the output.
- **Scoreboard:** 10k random `in_valid`/`out_ready`/`flush` cycles at `WIDTH=8` and `WIDTH=64` → output order matches the reference queue; no loss except flush; `in_ready=~s_valid` every cycle.
